// File: rtl/routing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : routing_pkg
//  Description : Shared types and constants for the ping-pong buffer
//                controllers (write side and read side).
//                  pp_state_t  - fill/stall state of a ping-pong controller
//                  bank_id_t   - identifies bank 0 or bank 1
//                  FRAME_WORDS - words in one 28x28 frame
//  Revision    : 1.0  initial release
// ============================================================================
package routing_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        STALL = 1'b1
    } pp_state_t;

    typedef logic bank_id_t;

    localparam int FRAME_WORDS = 784;

endpackage : routing_pkg
`default_nettype wire

// File: rtl/bank_addr_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bank_addr_counter
//  Description : Modulo-DEPTH address counter with enable and synchronous
//                clear. o_wrap flags the enabled cycle on which the count
//                sits at DEPTH-1 and is about to return to 0. Shared by the
//                write-side and read-side ping-pong controllers.
//  Ports       : clk      - system clock
//                reset_n  - asynchronous active-low reset
//                i_clr    - synchronous clear to 0 (overrides i_en)
//                i_en     - advance the count this cycle
//                o_count  - current count, 0..DEPTH-1
//                o_wrap   - i_en while o_count == DEPTH-1
//  Revision    : 1.0  initial release
// ============================================================================
module bank_addr_counter #(
    parameter int DEPTH  = 784,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_count,
    output logic              o_wrap
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] r_count;

    // Wrap is gated by i_clr so a flushed cycle never reports completion.
    assign o_wrap  = i_en & ~i_clr & (r_count == c_last);
    assign o_count = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            if (r_count == c_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule : bank_addr_counter
`default_nettype wire

// File: rtl/pingpong_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pingpong_bank_ctrl
//  Description : Steers a producer word stream into two alternating buffer
//                banks. Writes are combinational (zero latency); the bank
//                select, fill counter, full flags and frame_done pulse are
//                registered. When both banks hold unconsumed frames the
//                producer is stalled until the consumer releases the bank
//                that is next in line for filling.
//  Ports       : clk, reset_n        - clock, async active-low reset
//                clear               - synchronous flush of all fill state
//                in_data/in_valid    - producer stream
//                in_ready            - controller accepts a word this cycle
//                wr_sel              - bank being filled (demux select)
//                wr_data/wr_addr     - write data / address to the banks
//                wr_en_0/wr_en_1     - per-bank write strobes
//                bank_full           - bit i: bank i holds a complete frame
//                bank_release        - bit i pulse: consumer done with bank i
//                frame_done          - one-cycle pulse after a bank completes
//  Revision    : 1.0  initial release
// ============================================================================
module pingpong_bank_ctrl
    import routing_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = FRAME_WORDS,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 wr_sel,
    output logic [WORD_SIZE-1:0] wr_data,
    output logic                 wr_en_0,
    output logic                 wr_en_1,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [1:0]           bank_full,
    input  logic [1:0]           bank_release,
    output logic                 frame_done
);

    pp_state_t   r_state;
    bank_id_t    r_wr_sel;
    logic [1:0]  r_bank_full;
    logic        r_frame_done;

    logic        w_accept;
    logic        w_wrap;
    bank_id_t    w_other;
    logic [1:0]  w_full_next;

    // clear suppresses the write strobe outright so a flushed word never
    // lands in a bank.
    assign w_accept = in_valid & (r_state == FILL) & ~clear;
    assign w_other  = ~r_wr_sel;

    bank_addr_counter #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_wr_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (clear),
        .i_en    (w_accept),
        .o_count (wr_addr),
        .o_wrap  (w_wrap)
    );

    // Releases only clear bits that are already set. The completing bank is
    // set after the release mask, so a release of that bank in its own
    // completion cycle has no effect.
    always_comb begin
        w_full_next = r_bank_full & ~bank_release;
        if (w_wrap) begin
            w_full_next[r_wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= FILL;
            r_wr_sel     <= 1'b0;
            r_bank_full  <= 2'b00;
            r_frame_done <= 1'b0;
        end else if (clear) begin
            r_state      <= FILL;
            r_wr_sel     <= 1'b0;
            r_bank_full  <= 2'b00;
            r_frame_done <= 1'b0;
        end else begin
            r_bank_full  <= w_full_next;
            r_frame_done <= w_wrap;
            case (r_state)
                FILL: begin
                    if (w_wrap) begin
                        r_wr_sel <= w_other;
                        r_state  <= w_full_next[w_other] ? STALL : FILL;
                    end
                end
                STALL: begin
                    // Resume as soon as the bank waiting to be refilled is freed.
                    if (!w_full_next[r_wr_sel]) begin
                        r_state <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign in_ready   = (r_state == FILL);
    assign wr_sel     = r_wr_sel;
    assign wr_data    = in_data;
    assign wr_en_0    = w_accept & ~r_wr_sel;
    assign wr_en_1    = w_accept &  r_wr_sel;
    assign bank_full  = r_bank_full;
    assign frame_done = r_frame_done;

endmodule : pingpong_bank_ctrl
`default_nettype wire

// File: tb/tb_pingpong_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pingpong_bank_ctrl
//  Description : Self-checking bench for pingpong_bank_ctrl with DEPTH=4.
//                Each accepted word pushes its expected bank/address/data
//                onto a queue; a negedge monitor pops and compares every
//                write strobe the controller produces.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pingpong_bank_ctrl;

    localparam int WORD_SIZE = 16;
    localparam int DEPTH     = 4;
    localparam int ADDR_W    = 2;

    typedef struct packed {
        logic              sel;
        logic [ADDR_W-1:0] addr;
        logic [WORD_SIZE-1:0] data;
    } wr_exp_t;

    logic                 clk;
    logic                 reset_n;
    logic                 clear;
    logic [WORD_SIZE-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 wr_sel;
    logic [WORD_SIZE-1:0] wr_data;
    logic                 wr_en_0;
    logic                 wr_en_1;
    logic [ADDR_W-1:0]    wr_addr;
    logic [1:0]           bank_full;
    logic [1:0]           bank_release;
    logic                 frame_done;

    int checks = 0;
    int errors = 0;

    wr_exp_t           exp_q[$];
    logic              m_sel;
    logic [ADDR_W-1:0] m_addr;

    pingpong_bank_ctrl #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .wr_sel       (wr_sel),
        .wr_data      (wr_data),
        .wr_en_0      (wr_en_0),
        .wr_en_1      (wr_en_1),
        .wr_addr      (wr_addr),
        .bank_full    (bank_full),
        .bank_release (bank_release),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every write strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (wr_en_0 || wr_en_1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: en0=%0b en1=%0b addr=%0d data=%h, required no write",
                         wr_en_0, wr_en_1, wr_addr, wr_data);
            end else begin
                wr_exp_t e;
                e = exp_q.pop_front();
                if ({wr_en_1, wr_en_0, wr_sel, wr_addr, wr_data} !==
                    {e.sel, ~e.sel, e.sel, e.addr, e.data}) begin
                    errors++;
                    $display("FAIL write_beat: en1=%0b en0=%0b sel=%0b addr=%0d data=%h, required bank=%0b addr=%0d data=%h",
                             wr_en_1, wr_en_0, wr_sel, wr_addr, wr_data, e.sel, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_sel  = 1'b0;
        m_addr = '0;
    endtask

    // Drives one accepted word (with an optional same-cycle release) and
    // records where it must land.
    task automatic push_word(input logic [WORD_SIZE-1:0] d, input logic [1:0] rel);
        wr_exp_t e;
        e.sel  = m_sel;
        e.addr = m_addr;
        e.data = d;
        exp_q.push_back(e);
        if (m_addr == ADDR_W'(DEPTH - 1)) begin
            m_addr = '0;
            m_sel  = ~m_sel;
        end else begin
            m_addr = m_addr + 1'b1;
        end
        in_data      = d;
        in_valid     = 1'b1;
        bank_release = rel;
        tick();
        in_valid     = 1'b0;
        bank_release = 2'b00;
    endtask

    task automatic check_status(input string name, input logic [1:0] full,
                                input logic sel, input logic [ADDR_W-1:0] addr,
                                input logic rdy, input logic fd);
        checks++;
        if ({bank_full, wr_sel, wr_addr, in_ready, frame_done} !== {full, sel, addr, rdy, fd}) begin
            errors++;
            $display("FAIL %s: full=%b sel=%0b addr=%0d ready=%0b done=%0b, required full=%b sel=%0b addr=%0d ready=%0b done=%0b",
                     name, bank_full, wr_sel, wr_addr, in_ready, frame_done, full, sel, addr, rdy, fd);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear = 1'b0; in_valid = 1'b0; in_data = '0; bank_release = 2'b00;
        model_reset();
        #2;
        checks++;
        if ({bank_full, wr_sel, wr_addr, frame_done, wr_en_0, wr_en_1} !== 7'b0) begin
            errors++;
            $display("FAIL reset_values: full=%b sel=%0b addr=%0d done=%0b en0=%0b en1=%0b, required all 0",
                     bank_full, wr_sel, wr_addr, frame_done, wr_en_0, wr_en_1);
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_status("after_reset", 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    endtask

    task automatic test_fill_bank0();
        for (int i = 0; i < DEPTH; i++) push_word(16'hA0 + 16'(i), 2'b00);
        check_status("bank0_complete", 2'b01, 1'b1, 2'd0, 1'b1, 1'b1);
        tick();
        check_status("frame_done_one_cycle", 2'b01, 1'b1, 2'd0, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < DEPTH; i++) push_word(16'hB0 + 16'(i), 2'b00);
        check_status("both_full_stall", 2'b11, 1'b0, 2'd0, 1'b0, 1'b1);
        in_data  = 16'hC0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({wr_en_0, wr_en_1} !== 2'b00) begin
                errors++;
                $display("FAIL stall_no_write: en0=%0b en1=%0b, required 0 0", wr_en_0, wr_en_1);
            end
            tick();
        end
        in_valid = 1'b0;
        check_status("stall_held", 2'b11, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_release_from_stall();
        bank_release = 2'b01;
        tick();
        bank_release = 2'b00;
        check_status("release_resume", 2'b10, 1'b0, 2'd0, 1'b1, 1'b0);
        push_word(16'hD0, 2'b00);
        check_status("write_after_release", 2'b10, 1'b0, 2'd1, 1'b1, 1'b0);
    endtask

    task automatic test_release_on_completion();
        push_word(16'hD1, 2'b00);
        push_word(16'hD2, 2'b00);
        push_word(16'hD3, 2'b10);
        check_status("complete_with_release", 2'b01, 1'b1, 2'd0, 1'b1, 1'b1);
        push_word(16'hE0, 2'b00);
        push_word(16'hE1, 2'b00);
        check_status("bank1_partial", 2'b01, 1'b1, 2'd2, 1'b1, 1'b0);
    endtask

    task automatic test_clear();
        in_data      = 16'hF2;
        in_valid     = 1'b1;
        clear        = 1'b1;
        bank_release = 2'b01;
        @(negedge clk);
        checks++;
        if ({wr_en_0, wr_en_1} !== 2'b00) begin
            errors++;
            $display("FAIL clear_no_write: en0=%0b en1=%0b, required 0 0", wr_en_0, wr_en_1);
        end
        tick();
        clear = 1'b0; in_valid = 1'b0; bank_release = 2'b00;
        model_reset();
        check_status("after_clear", 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        bank_release = 2'b11;
        tick();
        bank_release = 2'b00;
        check_status("release_empty_ignored", 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        // Release of bank 0 in its own completion cycle must not clear it.
        for (int i = 0; i < DEPTH; i++)
            push_word(16'h100 + 16'(i), (i == DEPTH - 1) ? 2'b01 : 2'b00);
        check_status("self_release_ignored", 2'b01, 1'b1, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) push_word(16'h200 + 16'(i), 2'b00);
        check_status("b2b_stall", 2'b11, 1'b0, 2'd0, 1'b0, 1'b1);
        bank_release = 2'b11;
        tick();
        bank_release = 2'b00;
        check_status("release_both", 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < DEPTH - 1; i++) push_word(16'h300 + 16'(i), 2'b00);
        check_status("pre_reset_partial", 2'b00, 1'b0, 2'd3, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bank_full, wr_sel, wr_addr, frame_done} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: full=%b sel=%0b addr=%0d done=%0b, required all 0",
                     bank_full, wr_sel, wr_addr, frame_done);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (frame_done !== 1'b0) begin
                errors++;
                $display("FAIL no_frame_done_in_reset: done=%0b, required 0", frame_done);
            end
        end
        reset_n = 1'b1;
        model_reset();
        tick();
        check_status("after_async_reset", 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
        push_word(16'h3FF, 2'b00);
        check_status("fresh_frame_start", 2'b00, 1'b0, 2'd1, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill_bank0();
        test_stall();
        test_release_from_stall();
        test_release_on_completion();
        test_clear();
        test_back_to_back();
        test_async_reset();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: pending=%0d, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pingpong_bank_ctrl
`default_nettype wire
